data_mem_responder: RTL and testbench

- Memory-side responder for the CPU data port. It services the MemRead/MemWrite requests issued from the MEM stage.
- It owns a word-addressed data RAM and models a fixed multi-cycle access latency.
- While an access is in flight it holds the pipeline with mem_stall. The hazard unit ORs mem_stall into its EXMEM/MEMWB stall terms.
- When the access completes, it returns registered read data.

---
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 tb/tb_data_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data port. Accepts a MemRead/MemWrite
//   request from the MEM stage and services it against a word-addressed RAM.
//   The access takes a fixed number of cycles, and mem_stall holds the
//   pipeline during that time. Load data comes back registered.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset (also clears the RAM)
//   MemRead      read request, level, held by the pipeline while stalled
//   MemWrite     write request, level, held while stalled
//   addr         word address; only addr[ADDR_BITS-1:0] is used (wraps)
//   write_data   store data
//   read_data    registered load data, held until the next read completes
//   mem_stall    access in progress, MEM stage must hold
//   access_done  one-cycle pulse in the final (DONE) cycle of an access
//   req_conflict sticky: MemRead and MemWrite were both seen at acceptance
//   read_count   completed reads (wraps)
//   write_count  completed writes (wraps)
module data_mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] write_data,
  output logic [WORD_SIZE-1:0] read_data,
  output logic                 mem_stall,
  output logic                 access_done,
  output logic                 req_conflict,
  output logic [WORD_SIZE-1:0] read_count,
  output logic [WORD_SIZE-1:0] write_count
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   op_write;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [WORD_SIZE-1:0]   lat_data;
  logic [WORD_SIZE-1:0]   ram [DEPTH];

  logic                   req;
  logic                   commit;
  logic                   commit_write;
  logic [ADDR_BITS-1:0]   commit_addr;
  logic [WORD_SIZE-1:0]   commit_data;

  // Upper address bits are deliberately dropped so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[WORD_SIZE-1:ADDR_BITS];

  assign req = MemRead | MemWrite;

  // The requesting cycle stalls immediately (combinational in IDLE); the
  // DONE cycle releases the pipeline.
  assign mem_stall   = (state == IDLE) ? req : (state == BUSY);
  assign access_done = (state == DONE);

  // The commit happens on the edge that enters DONE. With LATENCY==1 that
  // is the acceptance edge itself, so the live inputs are used; otherwise
  // it is the last BUSY edge and the latched request is used.
  always_comb begin
    commit       = 1'b0;
    commit_write = op_write;
    commit_addr  = lat_addr;
    commit_data  = lat_data;
    if (state == IDLE && req && LATENCY == 1) begin
      commit       = 1'b1;
      commit_write = MemWrite;
      commit_addr  = addr[ADDR_BITS-1:0];
      commit_data  = write_data;
    end else if (state == BUSY && cnt == 4'd1) begin
      commit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      op_write     <= 1'b0;
      lat_addr     <= '0;
      lat_data     <= '0;
      read_data    <= '0;
      req_conflict <= 1'b0;
      read_count   <= '0;
      write_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // A simultaneous read+write is flagged and treated as a write.
            op_write <= MemWrite;
            lat_addr <= addr[ADDR_BITS-1:0];
            lat_data <= write_data;
            cnt      <= CNT_INIT;
            if (MemRead && MemWrite) begin
              req_conflict <= 1'b1;
            end
            state <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= DONE;
          end
        end
        // The request still visible here is the one just completed.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit) begin
        if (commit_write) begin
          ram[commit_addr] <= commit_data;
          write_count      <= write_count + WORD_SIZE'(1);
        end else begin
          read_data  <= ram[commit_addr];
          read_count <= read_count + WORD_SIZE'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Three instances run side by side with
// LATENCY = 1, 2 and 4; each has its own request inputs and a shared reset.
module tb_data_mem_responder;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read  [NDUT];
  logic        mem_write [NDUT];
  logic [15:0] addr_s    [NDUT];
  logic [15:0] wdata     [NDUT];
  logic [15:0] rdata     [NDUT];
  logic        stall     [NDUT];
  logic        done      [NDUT];
  logic        conflict  [NDUT];
  logic [15:0] rcnt      [NDUT];
  logic [15:0] wcnt      [NDUT];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      data_mem_responder #(
        .WORD_SIZE(16),
        .ADDR_BITS(8),
        .LATENCY  ((gi == 0) ? 1 : ((gi == 1) ? 2 : 4))
      ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .MemRead     (mem_read[gi]),
        .MemWrite    (mem_write[gi]),
        .addr        (addr_s[gi]),
        .write_data  (wdata[gi]),
        .read_data   (rdata[gi]),
        .mem_stall   (stall[gi]),
        .access_done (done[gi]),
        .req_conflict(conflict[gi]),
        .read_count  (rcnt[gi]),
        .write_count (wcnt[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [15:0] m_ram  [NDUT][256];
  logic [15:0] m_rd   [NDUT];
  logic [15:0] m_rc   [NDUT];
  logic [15:0] m_wc   [NDUT];
  logic        m_conf [NDUT];

  typedef struct {
    logic [15:0] rdata;
    logic [15:0] rc;
    logic [15:0] wc;
    logic        conf;
  } sb_t;
  sb_t sb [$];

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      for (int j = 0; j < 256; j++) m_ram[i][j] = 16'h0000;
      m_rd[i]   = 16'h0000;
      m_rc[i]   = 16'h0000;
      m_wc[i]   = 16'h0000;
      m_conf[i] = 1'b0;
    end
  endtask

  task automatic push_expect(input int i, input bit rd, input bit wr,
                             input logic [15:0] a, input logic [15:0] d);
    sb_t e;
    if (rd && wr) m_conf[i] = 1'b1;
    if (wr) begin
      m_ram[i][a[7:0]] = d;
      m_wc[i] = m_wc[i] + 16'd1;
    end else begin
      m_rd[i] = m_ram[i][a[7:0]];
      m_rc[i] = m_rc[i] + 16'd1;
    end
    e.rdata = m_rd[i];
    e.rc    = m_rc[i];
    e.wc    = m_wc[i];
    e.conf  = m_conf[i];
    sb.push_back(e);
  endtask

  task automatic pop_compare(input int i, input string tag);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    check($sformatf("%s sb read_data", tag), rdata[i], e.rdata);
    check($sformatf("%s sb read_count", tag), rcnt[i], e.rc);
    check($sformatf("%s sb write_count", tag), wcnt[i], e.wc);
    check($sformatf("%s sb req_conflict", tag), 16'(conflict[i]), 16'(e.conf));
  endtask

  // Entered just after a rising edge. Holds the request through DONE, like
  // the pipeline does, then drops it and verifies it was not re-accepted.
  task automatic access(input int i, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input string tag);
    mem_read[i]  = rd;
    mem_write[i] = wr;
    addr_s[i]    = a;
    wdata[i]     = d;
    push_expect(i, rd, wr, a, d);
    for (int c = 0; c < lat_of(i); c++) begin
      @(negedge clk);
      check($sformatf("%s stall c%0d", tag, c), 16'(stall[i]), 16'h1);
      check($sformatf("%s done c%0d", tag, c), 16'(done[i]), 16'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check($sformatf("%s done pulse", tag), 16'(done[i]), 16'h1);
    check($sformatf("%s stall in DONE", tag), 16'(stall[i]), 16'h0);
    check($sformatf("%s read_data", tag), rdata[i], exp_rd);
    pop_compare(i, tag);
    $display("txn dut%0d %s rd=%0b wr=%0b addr=0x%04h data=0x%04h read_data=0x%04h rc=%0d wc=%0d conflict=%0b",
             i, tag, rd, wr, a, d, rdata[i], rcnt[i], wcnt[i], conflict[i]);
    @(posedge clk); #1;
    mem_read[i]  = 1'b0;
    mem_write[i] = 1'b0;
    @(negedge clk);
    check($sformatf("%s no re-accept stall", tag), 16'(stall[i]), 16'h0);
    check($sformatf("%s no re-accept done", tag), 16'(done[i]), 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s dut%0d stall", tag, i), 16'(stall[i]), 16'h0);
      check($sformatf("%s dut%0d done", tag, i), 16'(done[i]), 16'h0);
      check($sformatf("%s dut%0d conflict", tag, i), 16'(conflict[i]), 16'h0);
      check($sformatf("%s dut%0d read_data", tag, i), rdata[i], 16'h0000);
      check($sformatf("%s dut%0d read_count", tag, i), rcnt[i], 16'h0000);
      check($sformatf("%s dut%0d write_count", tag, i), wcnt[i], 16'h0000);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          idx;
    bit          rd;
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  initial begin
    // {dut, rd, wr, addr, write_data, read_data expected after completion}
    vecs[0]  = '{1, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000};
    vecs[1]  = '{1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[2]  = '{1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[3]  = '{1, 1'b0, 1'b1, 16'h0103, 16'h1234, 16'hBEEF};
    vecs[4]  = '{1, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h1234};
    vecs[5]  = '{1, 1'b0, 1'b1, 16'hFFFF, 16'h0F0F, 16'h1234};
    vecs[6]  = '{1, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0F0F};
    vecs[7]  = '{1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[8]  = '{0, 1'b0, 1'b1, 16'h0001, 16'hA5A5, 16'h0000};
    vecs[9]  = '{0, 1'b1, 1'b0, 16'h0101, 16'h0000, 16'hA5A5};
    vecs[10] = '{2, 1'b0, 1'b1, 16'h0020, 16'hAAAA, 16'h0000};
    vecs[11] = '{2, 1'b0, 1'b1, 16'h0021, 16'hBBBB, 16'h0000};

    reset_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      mem_read[i]  = 1'b0;
      mem_write[i] = 1'b0;
      addr_s[i]    = 16'h0000;
      wdata[i]     = 16'h0000;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NVEC; v++) begin
      access(vecs[v].idx, vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d,
             vecs[v].exp_rd, $sformatf("vec%0d", v));
    end

    // Inputs change mid-BUSY on the LATENCY=4 instance: latched request wins.
    mem_read[2] = 1'b1;
    addr_s[2]   = 16'h0020;
    wdata[2]    = 16'h0000;
    push_expect(2, 1'b1, 1'b0, 16'h0020, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        addr_s[2]    = 16'h0021;
        wdata[2]     = 16'hFFFF;
        mem_write[2] = 1'b1;
      end
      @(negedge clk);
      check($sformatf("midbusy stall c%0d", c), 16'(stall[2]), 16'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("midbusy done", 16'(done[2]), 16'h1);
    check("midbusy read_data", rdata[2], 16'hAAAA);
    pop_compare(2, "midbusy");
    $display("txn dut2 midbusy read addr=0x0020 (addr->0x0021 at c2) read_data=0x%04h", rdata[2]);
    @(posedge clk); #1;
    mem_read[2]  = 1'b0;
    mem_write[2] = 1'b0;
    addr_s[2]    = 16'h0000;
    @(negedge clk);
    check("midbusy no re-accept", 16'(stall[2]), 16'h0);
    @(posedge clk); #1;
    access(2, 1'b1, 1'b0, 16'h0021, 16'h0000, 16'hBBBB, "midbusy untouched");

    // Conflict: proceeds as a write, flag is sticky.
    @(negedge clk);
    check("conflict before", 16'(conflict[1]), 16'h0);
    @(posedge clk); #1;
    access(1, 1'b1, 1'b1, 16'h0030, 16'h5555, 16'hBEEF, "conflict");
    access(1, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555, "conflict readback");

    // Reset in BUSY abandons the write.
    mem_write[1] = 1'b1;
    addr_s[1]    = 16'h0040;
    wdata[1]     = 16'h7777;
    @(negedge clk);
    check("rst-mid stall accept", 16'(stall[1]), 16'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst-mid stall busy", 16'(stall[1]), 16'h1);
    reset_n      = 1'b0;
    mem_write[1] = 1'b0;
    #1;
    check_reset_state("rst-mid");
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    sb.delete();
    $display("txn dut1 write addr=0x0040 data=0x7777 abandoned by reset");
    access(1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, "rst-mid readback");
    access(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, "ram cleared");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
